// File: rtl/csr_counters.sv
// Machine-mode counter/CSR block: mcycle, minstret, N_HPM performance counters,
// mcountinhibit and the read-only identification CSRs. Reads are combinational.
module csr_counters #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned N_HPM   = 4,
  parameter logic [31:0] MARCHID = 32'h0531_8008
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wen,
  input  logic [11:0]       addr,
  input  logic [XLEN-1:0]   wdata,
  input  logic              is_instret,
  input  logic              is_ebreak,
  input  logic [N_HPM-1:0]  hpm_event,
  output logic [XLEN-1:0]   rdata,
  output logic              illegal
);

  localparam int unsigned   HW        = (N_HPM > 0) ? N_HPM : 1;
  localparam logic [1:0]    MXL       = (XLEN == 64) ? 2'd2 : 2'd1;
  localparam logic [XLEN-1:0] MISA    = (XLEN'(MXL) << (XLEN - 2)) | XLEN'(32'h0000_0100);
  localparam logic [31:0]   MVENDORID = 32'h6265_6B61;
  // CY, IR and one bit per implemented HPM counter; bit 1 (TM) stays 0
  localparam logic [31:0]   INH_MASK  = 32'h0000_0005 | (((32'h1 << N_HPM) - 32'h1) << 3);

  logic [63:0]   mcycle;
  logic [63:0]   minstret;
  logic [63:0]   hpm [HW];
  logic [31:0]   inhibit;

  logic          hit;
  logic          ro;
  logic          sel_hi;
  logic          sel_cyc;
  logic          sel_ins;
  logic          sel_inh;
  logic [HW-1:0] sel_hpm;
  logic          wr;

  function automatic logic [XLEN-1:0] rd_half(input logic [63:0] v, input logic hi);
    if (XLEN == 64) return XLEN'(v);
    return hi ? XLEN'(v[63:32]) : XLEN'(v[31:0]);
  endfunction

  function automatic logic [63:0] wr_half(input logic [63:0] v, input logic hi,
                                          input logic [XLEN-1:0] d);
    if (XLEN == 64) return 64'(d);
    return hi ? {d[31:0], v[31:0]} : {v[63:32], d[31:0]};
  endfunction

  // Address decode and read mux
  always_comb begin
    rdata   = '0;
    hit     = 1'b0;
    ro      = 1'b0;
    sel_hi  = 1'b0;
    sel_cyc = 1'b0;
    sel_ins = 1'b0;
    sel_inh = 1'b0;
    sel_hpm = '0;
    case (addr)
      12'h301: begin hit = 1'b1; ro = 1'b1; rdata = MISA; end
      12'hF11: begin hit = 1'b1; ro = 1'b1; rdata = XLEN'(MVENDORID); end
      12'hF12: begin hit = 1'b1; ro = 1'b1; rdata = XLEN'(MARCHID); end
      12'h320: begin hit = 1'b1; sel_inh = 1'b1; rdata = XLEN'(inhibit); end
      12'hB00: begin hit = 1'b1; sel_cyc = 1'b1; rdata = rd_half(mcycle, 1'b0); end
      12'hB02: begin hit = 1'b1; sel_ins = 1'b1; rdata = rd_half(minstret, 1'b0); end
      12'hB80: if (XLEN == 32) begin
        hit = 1'b1; sel_cyc = 1'b1; sel_hi = 1'b1; rdata = rd_half(mcycle, 1'b1);
      end
      12'hB82: if (XLEN == 32) begin
        hit = 1'b1; sel_ins = 1'b1; sel_hi = 1'b1; rdata = rd_half(minstret, 1'b1);
      end
      default: ;
    endcase
    for (int i = 0; i < N_HPM; i++) begin
      if (addr == 12'(12'hB03 + i)) begin
        hit = 1'b1; sel_hpm[i] = 1'b1; rdata = rd_half(hpm[i], 1'b0);
      end
      if (XLEN == 32 && addr == 12'(12'hB83 + i)) begin
        hit = 1'b1; sel_hpm[i] = 1'b1; sel_hi = 1'b1; rdata = rd_half(hpm[i], 1'b1);
      end
    end
  end

  assign illegal = !hit || (wen && ro);
  assign wr      = wen && hit && !ro;

  // Counter and inhibit update; a write to a counter suppresses its increment
  always_ff @(posedge clock) begin
    if (reset) begin
      mcycle   <= '0;
      minstret <= '0;
      inhibit  <= '0;
      for (int i = 0; i < HW; i++) hpm[i] <= '0;
    end else begin
      if (wr && sel_cyc)                  mcycle <= wr_half(mcycle, sel_hi, wdata);
      else if (!inhibit[0] && !is_ebreak) mcycle <= mcycle + 64'd1;

      if (wr && sel_ins)                  minstret <= wr_half(minstret, sel_hi, wdata);
      else if (is_instret && !inhibit[2]) minstret <= minstret + 64'd1;

      if (wr && sel_inh) inhibit <= wdata[31:0] & INH_MASK;

      for (int i = 0; i < N_HPM; i++) begin
        if (wr && sel_hpm[i])                         hpm[i] <= wr_half(hpm[i], sel_hi, wdata);
        else if (hpm_event[i] && !inhibit[3 + i])     hpm[i] <= hpm[i] + 64'd1;
      end
    end
  end

endmodule
